// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals around mem_port_arbiter.
// The master modport is the arbiter's view; slave is the surrounding core/memory view.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;

    logic        ls_readWr;
    logic        ls_writeWr;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_rmask;
    logic [3:0]  ls_wmask;
    logic [31:0] ls_rdata;
    logic        ls_ready;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_mask;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    logic        stall;
    logic        bus_err;

    modport master (
        input  if_req, if_addr,
        output if_rdata, if_ready,
        input  ls_readWr, ls_writeWr, ls_addr, ls_wdata, ls_rmask, ls_wmask,
        output ls_rdata, ls_ready,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_mask,
        input  mem_rdata, mem_ack,
        output stall, bus_err
    );

    modport slave (
        output if_req, if_addr,
        input  if_rdata, if_ready,
        output ls_readWr, ls_writeWr, ls_addr, ls_wdata, ls_rmask, ls_wmask,
        input  ls_rdata, ls_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_mask,
        output mem_rdata, mem_ack,
        input  stall, bus_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single data-memory port between instruction fetch and EXU load/store,
// with a timeout watchdog. Define ARB_RR_EN for round-robin grant under contention.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [15:0] TIMEOUT_C = TIMEOUT[15:0];

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  mask_q, mask_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;
    logic        if_ready_q, if_ready_d;
    logic        ls_ready_q, ls_ready_d;
    logic        bus_err_q, bus_err_d;
    logic [15:0] cnt_q, cnt_d;

    logic        ls_pending;
    logic        any_pending;
    logic        pick_data;
    logic [3:0]  grant_mask;
    logic [15:0] cnt_inc;
    logic [31:0] ack_rdata;
    logic        finish;
    logic [31:0] finish_rdata;

    assign ls_pending  = bus.ls_readWr | bus.ls_writeWr;
    assign any_pending = ls_pending | bus.if_req;
    assign cnt_inc     = cnt_q + 16'd1;
    // Only the data path can issue a write, and a store returns zero data.
    assign ack_rdata   = we_q ? 32'h0 : bus.mem_rdata;

`ifdef ARB_RR_EN
    logic last_data_q, last_data_d;

    // Under contention the requester that did not win the previous grant goes first.
    assign pick_data = ls_pending & (~bus.if_req | ~last_data_q);

    always_comb begin
        last_data_d = last_data_q;
        if (state_q == IDLE && any_pending) begin
            last_data_d = pick_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_data_q <= 1'b0;
        end else begin
            last_data_q <= last_data_d;
        end
    end
`else
    assign pick_data = ls_pending;
`endif

    // Byte mask chosen at grant: write mask beats read mask; fetch is a full word.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_mask
            assign grant_mask[gi] = pick_data
                                  ? (bus.ls_writeWr ? bus.ls_wmask[gi] : bus.ls_rmask[gi])
                                  : 1'b1;
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mask_d       = mask_q;
        if_rdata_d   = if_rdata_q;
        ls_rdata_d   = ls_rdata_q;
        if_ready_d   = 1'b0;
        ls_ready_d   = 1'b0;
        bus_err_d    = bus_err_q;
        cnt_d        = cnt_q;
        finish       = 1'b0;
        finish_rdata = 32'h0;

        case (state_q)
            IDLE: begin
                if (any_pending) begin
                    state_d = pick_data ? DATA : FETCH;
                    req_d   = 1'b1;
                    we_d    = pick_data & bus.ls_writeWr;
                    addr_d  = pick_data ? bus.ls_addr : bus.if_addr;
                    wdata_d = pick_data ? bus.ls_wdata : 32'h0;
                    mask_d  = grant_mask;
                    cnt_d   = 16'd0;
                end
            end
            FETCH, DATA: begin
                if (bus.mem_ack) begin
                    finish       = 1'b1;
                    finish_rdata = ack_rdata;
                end else if (cnt_inc == TIMEOUT_C) begin
                    // Dead memory: abort with zero data and flag it until reset.
                    finish       = 1'b1;
                    finish_rdata = 32'h0;
                    bus_err_d    = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end

                if (finish) begin
                    req_d   = 1'b0;
                    state_d = RESP;
                    if (state_q == FETCH) begin
                        if_rdata_d = finish_rdata;
                        if_ready_d = 1'b1;
                    end else begin
                        ls_rdata_d = finish_rdata;
                        ls_ready_d = 1'b1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            mask_q     <= 4'h0;
            if_rdata_q <= 32'h0;
            ls_rdata_q <= 32'h0;
            if_ready_q <= 1'b0;
            ls_ready_q <= 1'b0;
            bus_err_q  <= 1'b0;
            cnt_q      <= 16'd0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            mask_q     <= mask_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
            if_ready_q <= if_ready_d;
            ls_ready_q <= ls_ready_d;
            bus_err_q  <= bus_err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_mask  = mask_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.ls_rdata  = ls_rdata_q;
    assign bus.ls_ready  = ls_ready_q;
    assign bus.bus_err   = bus_err_q;
    assign bus.stall     = ~rst & ((bus.if_req & ~if_ready_q) | (ls_pending & ~ls_ready_q));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed steps plus randomized accesses
// against a word-memory reference model; a second instance with TIMEOUT=4 covers the watchdog.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if a ();
    mem_port_arbiter_if b ();

    mem_port_arbiter dut (.clk(clk), .rst(rst), .bus(a));
    mem_port_arbiter #(.TIMEOUT(4)) dut_to (.clk(clk), .rst(rst), .bus(b));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Responder memory (what the fake memory holds) and reference memory (what the core expects).
    bit [31:0] resp_mem [bit [29:0]];
    bit [31:0] ref_mem  [bit [29:0]];

    function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] wd, input bit [3:0] m);
        bit [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    function automatic bit [31:0] ref_rd(input logic [31:0] addr);
        return ref_mem.exists(addr[31:2]) ? ref_mem[addr[31:2]] : 32'h0;
    endfunction

    function automatic bit [31:0] resp_rd(input logic [31:0] addr);
        return resp_mem.exists(addr[31:2]) ? resp_mem[addr[31:2]] : 32'h0;
    endfunction

    // Memory responder for instance a: ack ack_delay cycles after mem_req rises.
    logic        resp_ack   = 1'b0;
    logic        force_ack  = 1'b0;
    logic [31:0] resp_rdata = 32'h0;
    int          ack_delay  = 0;
    int          req_age    = 0;

    assign a.mem_ack   = resp_ack | force_ack;
    assign a.mem_rdata = resp_rdata;

    always @(negedge clk) begin
        resp_ack = 1'b0;
        if (a.mem_req) begin
            if (req_age == ack_delay) begin
                resp_ack   = 1'b1;
                resp_rdata = resp_rd(a.mem_addr);
                if (a.mem_we)
                    resp_mem[a.mem_addr[31:2]] = merge(resp_rd(a.mem_addr), a.mem_wdata, a.mem_mask);
            end
            req_age++;
        end else begin
            req_age = 0;
        end
    end

    bit model_last_data = 1'b0;

    // Called at an IDLE negedge with requests already driven; runs one grant to completion.
    task automatic serve(input bit exp_data, input logic [31:0] exp_addr, input bit exp_we,
                         input logic [3:0] exp_mask, input logic [31:0] exp_rdata,
                         input int delay, input string tag);
        int   k;
        int   rises;
        logic prev;
        ack_delay = delay;
        @(negedge clk);
        k = 1;
        rises = a.mem_req ? 1 : 0;
        prev = a.mem_req;
        check({tag, "_req"},  a.mem_req, 1);
        check({tag, "_addr"}, a.mem_addr, exp_addr);
        check({tag, "_we"},   a.mem_we, exp_we);
        check({tag, "_mask"}, a.mem_mask, exp_mask);
        while (!(a.if_ready | a.ls_ready) && k < 40) begin
            check({tag, "_stall"}, a.stall, 1);
            @(negedge clk);
            k++;
            if (a.mem_req & ~prev) rises++;
            prev = a.mem_req;
        end
        check({tag, "_lat"},   k, delay + 2);
        check({tag, "_rises"}, rises, 1);
        check({tag, "_ifrdy"}, a.if_ready, !exp_data);
        check({tag, "_lsrdy"}, a.ls_ready, exp_data);
        if (exp_data) check({tag, "_lsrdata"}, a.ls_rdata, exp_rdata);
        else          check({tag, "_ifrdata"}, a.if_rdata, exp_rdata);
        if (exp_data) begin
            a.ls_readWr  = 1'b0;
            a.ls_writeWr = 1'b0;
        end else begin
            a.if_req = 1'b0;
        end
        model_last_data = exp_data;
        @(negedge clk);
        check({tag, "_rdyoff"}, {a.if_ready, a.ls_ready}, 0);
        check({tag, "_reqoff"}, a.mem_req, 0);
        check({tag, "_stallpost"}, a.stall, a.if_req | a.ls_readWr | a.ls_writeWr);
    endtask

    // Fetch and load raised together; order follows the arbitration rule.
    task automatic contend(input logic [31:0] fa, input logic [31:0] la, input int delay, input string tag);
        bit data_first;
`ifdef ARB_RR_EN
        data_first = !model_last_data;
`else
        data_first = 1'b1;
`endif
        a.if_req = 1'b1; a.if_addr = fa;
        a.ls_readWr = 1'b1; a.ls_addr = la; a.ls_rmask = 4'hF;
        if (data_first) begin
            serve(1, la, 0, 4'hF, ref_rd(la), delay, {tag, "_d1"});
            serve(0, fa, 0, 4'hF, ref_rd(fa), delay, {tag, "_f2"});
        end else begin
            serve(0, fa, 0, 4'hF, ref_rd(fa), delay, {tag, "_f1"});
            serve(1, la, 0, 4'hF, ref_rd(la), delay, {tag, "_d2"});
        end
    endtask

    task automatic preload(input logic [31:0] addr, input bit [31:0] val);
        resp_mem[addr[31:2]] = val;
        ref_mem[addr[31:2]]  = val;
    endtask

    initial begin
        int          k;
        int          nreq;
        int          kind;
        logic [31:0] ad, fa, wd;
        logic [3:0]  m;
        int          dl;

        a.if_req = 0; a.if_addr = 0; a.ls_readWr = 0; a.ls_writeWr = 0;
        a.ls_addr = 0; a.ls_wdata = 0; a.ls_rmask = 0; a.ls_wmask = 0;
        b.if_req = 0; b.if_addr = 0; b.ls_readWr = 0; b.ls_writeWr = 0;
        b.ls_addr = 0; b.ls_wdata = 0; b.ls_rmask = 0; b.ls_wmask = 0;
        b.mem_ack = 0; b.mem_rdata = 0;
        preload(32'h0040_0000, 32'h3C01_1001);
        preload(32'h1001_0004, 32'hDEAD_0000);

        // Reset state, with a fetch request held to confirm stall stays low under reset.
        rst = 1'b1;
        a.if_req = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_memreq", a.mem_req, 0);
        check("rst_memwe", a.mem_we, 0);
        check("rst_addr", a.mem_addr, 0);
        check("rst_mask", a.mem_mask, 0);
        check("rst_ready", {a.if_ready, a.ls_ready}, 0);
        check("rst_buserr", a.bus_err, 0);
        check("rst_stall", a.stall, 0);
        check("rst_rdata", a.if_rdata | a.ls_rdata, 0);
        a.if_req = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("idle_stall", a.stall, 0);

        // Single fetch.
        a.if_addr = 32'h0040_0000; a.if_req = 1'b1;
        serve(0, 32'h0040_0000, 0, 4'hF, 32'h3C01_1001, 0, "fetch");

        // Store low half, then load full word.
        a.ls_writeWr = 1'b1; a.ls_addr = 32'h1001_0004; a.ls_wdata = 32'hDEAD_BEEF; a.ls_wmask = 4'b0011;
        ref_mem[30'(32'h1001_0004 >> 2)] = merge(ref_rd(32'h1001_0004), 32'hDEAD_BEEF, 4'b0011);
        serve(1, 32'h1001_0004, 1, 4'b0011, 32'h0, 0, "store");
        a.ls_readWr = 1'b1; a.ls_addr = 32'h1001_0004; a.ls_rmask = 4'hF;
        serve(1, 32'h1001_0004, 0, 4'hF, ref_rd(32'h1001_0004), 0, "load");
        check("load_value", a.ls_rdata, 32'hDEAD_BEEF);

        // Read and write raised together is a write.
        a.ls_readWr = 1'b1; a.ls_writeWr = 1'b1; a.ls_addr = 32'h1001_0008;
        a.ls_wdata = 32'h0123_4567; a.ls_rmask = 4'hF; a.ls_wmask = 4'b1100;
        ref_mem[30'(32'h1001_0008 >> 2)] = merge(ref_rd(32'h1001_0008), 32'h0123_4567, 4'b1100);
        serve(1, 32'h1001_0008, 1, 4'b1100, 32'h0, 1, "rdwr");

        // Contention right after a data grant.
        contend(32'h0040_0000, 32'h1001_0008, 0, "cont");

        // Slow memory.
        a.ls_readWr = 1'b1; a.ls_addr = 32'h1001_0004; a.ls_rmask = 4'hF;
        serve(1, 32'h1001_0004, 0, 4'hF, ref_rd(32'h1001_0004), 10, "slow");

        // Randomized accesses over a small address window.
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 3);
            ad = 32'h0000_2000 + ($urandom_range(0, 3) << 2);
            fa = 32'h0000_2000 + ($urandom_range(0, 3) << 2);
            wd = $urandom;
            m  = 4'($urandom_range(1, 15));
            dl = $urandom_range(0, 3);
            case (kind)
                0: begin
                    a.if_req = 1'b1; a.if_addr = fa;
                    serve(0, fa, 0, 4'hF, ref_rd(fa), dl, "rnd_f");
                end
                1: begin
                    a.ls_readWr = 1'b1; a.ls_addr = ad; a.ls_rmask = m;
                    serve(1, ad, 0, m, ref_rd(ad), dl, "rnd_ld");
                end
                2: begin
                    a.ls_writeWr = 1'b1; a.ls_addr = ad; a.ls_wdata = wd; a.ls_wmask = m;
                    ref_mem[ad[31:2]] = merge(ref_rd(ad), wd, m);
                    serve(1, ad, 1, m, 32'h0, dl, "rnd_st");
                end
                default: contend(fa, ad, dl, "rnd_c");
            endcase
        end

        // Watchdog on the TIMEOUT=4 instance with mem_ack held low.
        b.ls_readWr = 1'b1; b.ls_addr = 32'h0000_3000; b.ls_rmask = 4'hF;
        k = 0; nreq = 0;
        do begin
            @(negedge clk);
            k++;
            if (b.mem_req) nreq++;
        end while (!b.ls_ready && k < 20);
        check("to_reqcycles", nreq, 4);
        check("to_ready", b.ls_ready, 1);
        check("to_rdata", b.ls_rdata, 0);
        check("to_buserr", b.bus_err, 1);
        check("to_memreq", b.mem_req, 0);
        b.ls_readWr = 1'b0;
        @(negedge clk);
        check("to_sticky", b.bus_err, 1);
        check("to_rdyoff", b.ls_ready, 0);
        b.mem_rdata = 32'h1234_5678; b.mem_ack = 1'b1;
        b.if_req = 1'b1; b.if_addr = 32'h0000_3004;
        @(negedge clk);
        check("to2_req", b.mem_req, 1);
        @(negedge clk);
        check("to2_ready", b.if_ready, 1);
        check("to2_rdata", b.if_rdata, 32'h1234_5678);
        b.if_req = 1'b0; b.mem_ack = 1'b0;
        @(negedge clk);
        check("to2_sticky", b.bus_err, 1);
        check("to2_rdyoff", b.if_ready, 0);

        // Reset in the middle of a slow load.
        ack_delay = 8;
        a.ls_readWr = 1'b1; a.ls_addr = 32'h1001_0004; a.ls_rmask = 4'hF;
        @(negedge clk);
        check("mid_req", a.mem_req, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_memreq", a.mem_req, 0);
        check("mid_addr", a.mem_addr, 0);
        check("mid_mask", a.mem_mask, 0);
        check("mid_ready", {a.if_ready, a.ls_ready}, 0);
        check("mid_stall", a.stall, 0);
        check("mid_buserr_to", b.bus_err, 0);
        rst = 1'b0;
        a.ls_readWr = 1'b0;
        force_ack = 1'b1;
        model_last_data = 1'b0;
        @(negedge clk);
        check("late_ack_rdy", {a.if_ready, a.ls_ready}, 0);
        check("late_ack_req", a.mem_req, 0);
        force_ack = 1'b0;
        @(negedge clk);
        check("late_ack_rdy2", {a.if_ready, a.ls_ready}, 0);

        // Port still usable after the reset.
        a.if_req = 1'b1; a.if_addr = 32'h0040_0000;
        serve(0, 32'h0040_0000, 0, 4'hF, 32'h3C01_1001, 0, "post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
